// File: rtl/adder_arbiter.sv
// Round-robin arbiter granting four requesters access to one shared multi-cycle adder.
// Operands are latched at grant and held until the adder strobes ready or the wait times out.
module adder_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              req,
  input  logic [4*DATA_WIDTH-1:0] op_a,
  input  logic [4*DATA_WIDTH-1:0] op_b,
  input  logic [3:0]              op_add,
  output logic [3:0]              gnt,
  output logic [3:0]              done,
  output logic [DATA_WIDTH-1:0]   res,
  output logic                    err,
  output logic [DATA_WIDTH-1:0]   add_a,
  output logic [DATA_WIDTH-1:0]   add_b,
  output logic                    add_en,
  output logic                    add_enable,
  input  logic                    add_ready,
  input  logic [DATA_WIDTH-1:0]   add_result
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  state_t                state_q;
  logic [1:0]            ptr_q;
  logic [1:0]            win_q;
  logic [1:0]            win_d;
  logic [7:0]            cnt_q;
  logic [3:0]            gnt_q;
  logic [3:0]            done_q;
  logic [DATA_WIDTH-1:0] res_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] add_a_q;
  logic [DATA_WIDTH-1:0] add_b_q;
  logic                  add_en_q;
  logic                  add_enable_q;
  logic [DATA_WIDTH-1:0] a_d;
  logic [DATA_WIDTH-1:0] b_d;

  // Scan from the farthest offset down so the requester closest to ptr_q wins.
  always_comb begin
    win_d = ptr_q;
    for (int j = 3; j >= 0; j--) begin
      if (req[ptr_q + 2'(j)]) win_d = ptr_q + 2'(j);
    end
  end

  assign a_d = op_a[32'(win_d) * DATA_WIDTH +: DATA_WIDTH];
  assign b_d = op_b[32'(win_d) * DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= 2'd0;
      win_q        <= 2'd0;
      cnt_q        <= 8'd0;
      gnt_q        <= 4'd0;
      done_q       <= 4'd0;
      res_q        <= '0;
      err_q        <= 1'b0;
      add_a_q      <= '0;
      add_b_q      <= '0;
      add_en_q     <= 1'b0;
      add_enable_q <= 1'b0;
    end else begin
      done_q <= 4'd0;
      err_q  <= 1'b0;
      res_q  <= '0;
      case (state_q)
        IDLE: begin
          if (|req) begin
            add_a_q      <= a_d;
            add_b_q      <= b_d;
            add_en_q     <= op_add[win_d];
            gnt_q        <= 4'b0001 << win_d;
            win_q        <= win_d;
            add_enable_q <= 1'b1;
            cnt_q        <= 8'd0;
            state_q      <= BUSY;
          end else begin
            gnt_q        <= 4'd0;
            add_enable_q <= 1'b0;
          end
        end
        BUSY: begin
          // A ready strobe on the final counted cycle still beats the timeout.
          if (add_ready) begin
            res_q        <= add_result;
            done_q       <= gnt_q;
            gnt_q        <= 4'd0;
            add_enable_q <= 1'b0;
            state_q      <= DONE;
          end else if (cnt_q == TO_CNT) begin
            done_q       <= gnt_q;
            err_q        <= 1'b1;
            gnt_q        <= 4'd0;
            add_enable_q <= 1'b0;
            state_q      <= DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DONE: begin
          ptr_q   <= win_q + 2'd1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign res        = res_q;
  assign err        = err_q;
  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign add_en     = add_en_q;
  assign add_enable = add_enable_q;

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, operand/result width; SHALL be even and >= 4.
REQ-002 Parameter TIMEOUT, default 15, maximum BUSY cycles waiting for add_ready; SHALL be 1..255.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req  input  4  per-requester request, bit i = requester i.
REQ-006 op_a  input  4*DATA_WIDTH  operand A, requester i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 op_b  input  4*DATA_WIDTH  operand B, same packing.
REQ-008 op_add  input  4  per-requester add_en value forwarded to the shared adder.
REQ-009 gnt  output  4  one-hot grant, held for the whole transaction.
REQ-010 done  output  4  one-cycle completion pulse to the granted requester.
REQ-011 res  output  DATA_WIDTH  result, valid only in the done cycle.
REQ-012 err  output  1  one-cycle pulse coincident with done on timeout.
REQ-013 add_a, add_b  output  DATA_WIDTH each  operands to shared multi-cycle adder.
REQ-014 add_en  output  1  operation select to shared adder.
REQ-015 add_enable  output  1  enable of shared adder; low restarts its sequence.
REQ-016 add_ready  input  1  adder result-valid strobe.
REQ-017 add_result  input  DATA_WIDTH  adder result.

Function
REQ-018 States: IDLE, BUSY, DONE; all outputs registered.
REQ-019 IDLE, req != 0: winner = first set bit searching rr_ptr, rr_ptr+1, ... mod 4; at that edge latch op_a/op_b/op_add of winner into add_a/add_b/add_en, set gnt[winner], add_enable=1, clear timeout counter, go BUSY.
REQ-020 IDLE, req == 0: stay IDLE, gnt=0, add_enable=0.
REQ-021 BUSY: add_a/add_b/add_en SHALL stay constant; requester input changes SHALL be ignored.
REQ-022 BUSY, add_ready sampled 1: at that edge res=add_result, done[winner]=1, add_enable=0, gnt=0, go DONE.
REQ-023 BUSY, add_ready 0: increment counter; when counter reaches TIMEOUT: res=0, done[winner]=1, err=1, add_enable=0, gnt=0, go DONE.
REQ-024 DONE: done, err, res cleared next edge; rr_ptr = (winner+1) mod 4; go IDLE. add_enable SHALL be low at least one full cycle between transactions.
REQ-025 Request withdrawn while granted: transaction completes, done still pulses.
REQ-026 Request sampled in DONE SHALL NOT be granted until following IDLE edge.
REQ-027 Latency with 3-cycle adder (ready high after 3rd enabled edge): grant edge k -> done visible after edge k+4; back-to-back grants every 6 cycles.
REQ-028 Fairness: any requester held high SHALL be granted within 4 transactions.
REQ-029 add_ready outside BUSY SHALL be ignored.

Reset
REQ-030 rst=1 at an edge: state IDLE, rr_ptr=0, counter=0, gnt=0, done=0, err=0, res=0, add_a=add_b=0, add_en=0, add_enable=0.
REQ-031 rst mid-BUSY SHALL abort silently: no done, no err.
REQ-032 rst has priority over all other inputs in the same cycle.

Verification
REQ-033 Single: req=0001, op_a[0]=0x12, op_b[0]=0x34, op_add[0]=1 -> gnt=0001 for 4 cycles, done=0001 with res=0x46, err=0.
REQ-034 Contention: req=1111 held -> grants 0001,0010,0100,1000,0001 in order, each done pulse to matching bit only.
REQ-035 Pointer: after requester 2 completes, req=0101 -> gnt=0001 (ptr=3 wraps to 0 before 2).
REQ-036 Timeout: adder model never raises add_ready, req=0010 -> done=0010, err=1, res=0 exactly TIMEOUT+1 cycles after grant.
REQ-037 Operand stability: change op_a[0] 0x12->0xFF during BUSY -> add_a stays 0x12, res=0x46.
REQ-038 Reset mid-BUSY: rst 1 cycle after grant -> all outputs 0 next cycle, no done; subsequent req=0100 -> gnt=0100.
